// File: rtl/enhanced_cpu_param.sv
// Parametrised accumulator processor: single-port program/data RAM plus a
// fetch/decode/execute FSM with IN handshake, carry/overflow flags and program load.
module enhanced_cpu_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out1,
    output logic              Aeq0,
    output logic              Apos,
    output logic              carry,
    output logic              ovf,
    output logic              halted,
    output logic [2:0]        ir
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_HALT, S_FETCH, S_LOADIR, S_DECODE, S_EXEC, S_INWAIT
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000, OP_STORE = 3'b001, OP_ADD  = 3'b010, OP_SUB  = 3'b011,
        OP_IN    = 3'b100, OP_JZ    = 3'b101, OP_JPOS = 3'b110, OP_HALT = 3'b111
    } opcode_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;

    opcode_t           op;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic              unused_ir_bits;

    assign op             = opcode_t'(ir_q[DATA_W-1 -: 3]);
    assign ir_addr        = ir_q[ADDR_W-1:0];
    assign unused_ir_bits = ^ir_q;

    assign sum     = {1'b0, a} + {1'b0, q};
    assign diff    = {1'b0, a} - {1'b0, q};
    assign add_ovf = (a[DATA_W-1] == q[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
    assign sub_ovf = (a[DATA_W-1] != q[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

    // The single RAM port is shared by program load, fetch, operand read and STORE.
    always_comb begin
        ram_addr  = pc;
        ram_wdata = a;
        ram_we    = 1'b0;
        case (state)
            S_HALT: begin
                ram_addr  = prog_addr;
                ram_wdata = prog_data;
                ram_we    = prog_we;
            end
            S_DECODE: begin
                ram_addr = ir_addr;
                ram_we   = (op == OP_STORE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        q <= mem[ram_addr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_HALT;
            pc    <= '0;
            ir_q  <= '0;
            a     <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_HALT: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH:  state <= S_LOADIR;
                S_LOADIR: begin
                    ir_q  <= q;
                    pc    <= pc + 1'b1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_ADD, OP_SUB: state <= S_EXEC;
                        OP_STORE: state <= S_FETCH;
                        OP_JZ: begin
                            if (a == '0)
                                pc <= ir_addr;
                            state <= S_FETCH;
                        end
                        OP_JPOS: begin
                            if (!a[DATA_W-1])
                                pc <= ir_addr;
                            state <= S_FETCH;
                        end
                        OP_IN:   state <= S_INWAIT;
                        OP_HALT: state <= S_HALT;
                    endcase
                end
                S_EXEC: begin
                    case (op)
                        OP_LOAD: a <= q;
                        OP_ADD: begin
                            a     <= sum[DATA_W-1:0];
                            carry <= sum[DATA_W];
                            ovf   <= add_ovf;
                        end
                        OP_SUB: begin
                            a     <= diff[DATA_W-1:0];
                            carry <= diff[DATA_W];
                            ovf   <= sub_ovf;
                        end
                        default: ;
                    endcase
                    state <= S_FETCH;
                end
                S_INWAIT: begin
                    if (in_valid) begin
                        a     <= in_data;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

    assign out1     = a;
    assign Aeq0     = (a == '0);
    assign Apos     = ~a[DATA_W-1];
    assign halted   = (state == S_HALT);
    assign in_ready = (state == S_INWAIT);
    assign ir       = ir_q[DATA_W-1 -: 3];

endmodule

// File: tb/tb_enhanced_cpu_param.sv
// Directed self-checking bench for enhanced_cpu_param (DATA_W=8, ADDR_W=5).
module tb_enhanced_cpu_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] out1;
    logic       Aeq0, Apos, carry, ovf, halted;
    logic [2:0] ir;

    int checks = 0;
    int errors = 0;

    enhanced_cpu_param #(.DATA_W(8), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .out1(out1), .Aeq0(Aeq0), .Apos(Apos), .carry(carry), .ovf(ovf),
        .halted(halted), .ir(ir)
    );

    always #5 clock = ~clock;

    task automatic load_word(input logic [4:0] addr, input logic [7:0] data);
        prog_addr = addr; prog_data = data; prog_we = 1'b1;
        @(posedge clock); #1;
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_halt(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            @(posedge clock); #1;
            cyc++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, cyc);
        end
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rst_halted: got %b req 1", halted); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b req 0", in_ready); end
        checks++; if (out1 !== 8'h00) begin errors++; $display("FAIL rst_out1: got %h req 00", out1); end
        checks++; if (Aeq0 !== 1'b1 || Apos !== 1'b1) begin errors++; $display("FAIL rst_aflags: got Aeq0=%b Apos=%b req 1 1", Aeq0, Apos); end
        checks++; if (carry !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_cv: got carry=%b ovf=%b req 0 0", carry, ovf); end
        checks++; if (ir !== 3'b000) begin errors++; $display("FAIL rst_ir: got %b req 000", ir); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        cyc = 0;
    endtask

    // IN, ADD, STORE, HALT; last word loaded in the same cycle as start.
    task automatic test_in_add_store();
        int cyc;
        in_data = 8'h7F; in_valid = 1'b1;
        load_word(5'd0, 8'h80);
        load_word(5'd1, 8'h5F);
        load_word(5'd2, 8'h3E);
        load_word(5'd3, 8'hE0);
        prog_addr = 5'd31; prog_data = 8'h01; prog_we = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        prog_we = 1'b0; start = 1'b0;
        wait_halt(100, cyc);
        checks++; if (cyc != 14) begin errors++; $display("FAIL t1_cycles: got %0d req 14", cyc); end
        checks++; if (out1 !== 8'h80) begin errors++; $display("FAIL t1_a: got %h req 80", out1); end
        checks++; if (ovf !== 1'b1 || carry !== 1'b0) begin errors++; $display("FAIL t1_cv: got carry=%b ovf=%b req 0 1", carry, ovf); end
        checks++; if (Apos !== 1'b0 || Aeq0 !== 1'b0) begin errors++; $display("FAIL t1_aflags: got Apos=%b Aeq0=%b req 0 0", Apos, Aeq0); end
        in_valid = 1'b0;
        // Read back the stored word through a LOAD 30 program.
        load_word(5'd0, 8'h1E);
        load_word(5'd1, 8'hE0);
        pulse_start();
        wait_halt(100, cyc);
        checks++; if (cyc != 7) begin errors++; $display("FAIL t1_load_cycles: got %0d req 7", cyc); end
        checks++; if (out1 !== 8'h80) begin errors++; $display("FAIL t1_ram30: got %h req 80", out1); end
    endtask

    task automatic test_sub_borrow();
        int cyc;
        load_word(5'd29, 8'h00);
        load_word(5'd28, 8'h01);
        load_word(5'd0, 8'h1D);
        load_word(5'd1, 8'h7C);
        load_word(5'd2, 8'hE0);
        pulse_start();
        wait_halt(100, cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL t2_cycles: got %0d req 11", cyc); end
        checks++; if (out1 !== 8'hFF) begin errors++; $display("FAIL t2_a: got %h req ff", out1); end
        checks++; if (carry !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL t2_cv: got carry=%b ovf=%b req 1 0", carry, ovf); end
        checks++; if (Aeq0 !== 1'b0 || Apos !== 1'b0) begin errors++; $display("FAIL t2_aflags: got Aeq0=%b Apos=%b req 0 0", Aeq0, Apos); end
    endtask

    task automatic test_countdown();
        int cyc;
        load_word(5'd20, 8'h05);
        load_word(5'd21, 8'h01);
        load_word(5'd0, 8'h14);
        load_word(5'd1, 8'h75);
        load_word(5'd2, 8'hA4);
        load_word(5'd3, 8'hC1);
        load_word(5'd4, 8'hE0);
        pulse_start();
        wait_halt(500, cyc);
        checks++; if (cyc != 54) begin errors++; $display("FAIL t3_cycles: got %0d req 54", cyc); end
        checks++; if (out1 !== 8'h00 || Aeq0 !== 1'b1) begin errors++; $display("FAIL t3_a: got A=%h Aeq0=%b req 00 1", out1, Aeq0); end
        checks++; if (carry !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL t3_cv: got carry=%b ovf=%b req 0 0", carry, ovf); end
    endtask

    task automatic test_in_wait();
        int cyc;
        in_valid = 1'b0; in_data = 8'hAA;
        load_word(5'd0, 8'h80);
        load_word(5'd1, 8'hE0);
        pulse_start();
        repeat (3) begin @(posedge clock); #1; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out1 !== 8'h00 || halted !== 1'b0 || ir !== 3'b100) begin
                errors++;
                $display("FAIL t4_wait[%0d]: got ready=%b A=%h halted=%b ir=%b req 1 00 0 100", i, in_ready, out1, halted, ir);
            end
            start = (i == 4);
            @(posedge clock); #1;
        end
        start = 1'b0;
        in_data = 8'h3C; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++; if (out1 !== 8'h3C) begin errors++; $display("FAIL t4_a: got %h req 3c", out1); end
        checks++; if (in_ready !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL t4_ready: got ready=%b halted=%b req 0 0", in_ready, halted); end
        wait_halt(100, cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL t4_tail: got %0d req 3", cyc); end
    endtask

    task automatic test_reset_mid_exec();
        int cyc;
        load_word(5'd31, 8'h7F);
        load_word(5'd30, 8'h01);
        load_word(5'd0, 8'h1F);
        load_word(5'd1, 8'h5E);
        load_word(5'd2, 8'hE0);
        pulse_start();
        repeat (7) begin @(posedge clock); #1; end
        checks++; if (ir !== 3'b010 || halted !== 1'b0 || out1 !== 8'h7F) begin errors++; $display("FAIL t5_pre: got ir=%b halted=%b A=%h req 010 0 7f", ir, halted, out1); end
        reset = 1'b0;
        #1;
        checks++; if (out1 !== 8'h00 || carry !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL t5_async: got A=%h carry=%b ovf=%b req 00 0 0", out1, carry, ovf); end
        checks++; if (halted !== 1'b1 || ir !== 3'b000) begin errors++; $display("FAIL t5_state: got halted=%b ir=%b req 1 000", halted, ir); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        pulse_start();
        wait_halt(100, cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL t5_cycles: got %0d req 11", cyc); end
        checks++; if (out1 !== 8'h80 || ovf !== 1'b1 || carry !== 1'b0) begin errors++; $display("FAIL t5_rerun: got A=%h ovf=%b carry=%b req 80 1 0", out1, ovf, carry); end
    endtask

    task automatic test_prog_we_running();
        int cyc;
        pulse_start();
        prog_addr = 5'd30; prog_data = 8'h10; prog_we = 1'b1;
        repeat (6) begin @(posedge clock); #1; end
        prog_we = 1'b0;
        wait_halt(100, cyc);
        checks++; if (out1 !== 8'h80) begin errors++; $display("FAIL t6_run: got %h req 80", out1); end
        pulse_start();
        wait_halt(100, cyc);
        checks++; if (out1 !== 8'h80) begin errors++; $display("FAIL t6_ram: got %h req 80", out1); end
    endtask

    initial begin
        start = 1'b0; in_data = '0; in_valid = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        test_reset();
        test_in_add_store();
        test_sub_borrow();
        test_countdown();
        test_in_wait();
        test_reset_mid_exec();
        test_prog_we_running();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
